ifetch_queue: RTL

- Instruction prefetch queue sitting directly upstream of the fetch stage of the 5-stage pipelined core.
- Issues sequential word fetches to instruction memory over a req/ack handshake and buffers the returned instructions with their PC and PC+4.
- Presents the buffered entries to the fetch stage through a valid/ready interface.
- Flushes its contents and restarts fetching when the execute stage redirects the PC on a branch, JAL or JALR.

---
 rtl/ifetch_queue.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: sequential word fetches over req/ack, buffered as {pc, instr, pc+4}.
// Optional macro IFQ_BYPASS_EN forwards an ack straight to deq_* when the queue is empty.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [31:0]              deq_instr,
  output logic [31:0]              deq_pc,
  output logic [31:0]              deq_pcplus4,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               dbgState
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DISCARD = 2'd2} state_t;

  state_t        state, stateNext;
  logic [31:0]   fetchPc, discardAddr, redirTarget;
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   cnt, cntNext;
  logic [31:0]   instrMem [DEPTH];
  logic [31:0]   pcMem    [DEPTH];
  logic [31:0]   pc4Mem   [DEPTH];
  logic [31:0]   lastInstr, lastPc, lastPc4;
  logic          accept, bypass, enq, deq;

  // Handshakes: imem transfer when imem_req & imem_ack; a queue entry is consumed when
  // deq_valid & deq_ready. Redirect overrides both in the cycle it is high.
  assign redirTarget = {redirect_pc[31:2], 2'b00};
  assign accept      = (state == REQ) & imem_ack & ~redirect;
`ifdef IFQ_BYPASS_EN
  assign bypass      = accept & (cnt == '0);
`else
  assign bypass      = 1'b0;
`endif
  assign enq         = accept & ~(bypass & deq_ready);
  assign deq         = (cnt != '0) & deq_ready & ~redirect;

  always_comb begin
    cntNext = cnt + {{AW{1'b0}}, enq} - {{AW{1'b0}}, deq};
    if (redirect) cntNext = '0;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // FSM: next state
  always_comb begin
    stateNext = state;
    if (redirect) begin
      case (state)
        REQ:     stateNext = imem_ack ? REQ : DISCARD;
        DISCARD: stateNext = DISCARD;
        default: stateNext = REQ;
      endcase
    end else begin
      case (state)
        IDLE:    stateNext = (cntNext < FULL) ? REQ : IDLE;
        REQ:     if (imem_ack) stateNext = (cntNext < FULL) ? REQ : IDLE;
        DISCARD: if (imem_ack) stateNext = REQ;
        default: stateNext = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    imem_req  = (state != IDLE);
    imem_addr = (state == DISCARD) ? discardAddr : fetchPc;
    dbgState  = state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetchPc     <= RESET_PC;
      discardAddr <= RESET_PC;
      wrPtr       <= '0;
      rdPtr       <= '0;
      cnt         <= '0;
      lastInstr   <= '0;
      lastPc      <= '0;
      lastPc4     <= '0;
    end else begin
      cnt <= cntNext;
      if (redirect) begin
        fetchPc <= redirTarget;
        wrPtr   <= '0;
        rdPtr   <= '0;
        // The abandoned request keeps its address until its ack is absorbed.
        if (state == REQ && !imem_ack) discardAddr <= fetchPc;
      end else begin
        if (accept) fetchPc <= fetchPc + 32'd4;
        if (enq)    wrPtr   <= wrPtr + 1'b1;
        if (deq)    rdPtr   <= rdPtr + 1'b1;
      end
      if (deq_valid) begin
        lastInstr <= deq_instr;
        lastPc    <= deq_pc;
        lastPc4   <= deq_pcplus4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      instrMem[wrPtr] <= imem_rdata;
      pcMem[wrPtr]    <= fetchPc;
      pc4Mem[wrPtr]   <= fetchPc + 32'd4;
    end
  end

  // Head entry when occupied, otherwise the last presented entry is held.
  always_comb begin
    deq_valid   = (cnt != '0);
    deq_instr   = lastInstr;
    deq_pc      = lastPc;
    deq_pcplus4 = lastPc4;
    if (cnt != '0) begin
      deq_instr   = instrMem[rdPtr];
      deq_pc      = pcMem[rdPtr];
      deq_pcplus4 = pc4Mem[rdPtr];
    end else if (bypass) begin
      deq_valid   = 1'b1;
      deq_instr   = imem_rdata;
      deq_pc      = imem_addr;
      deq_pcplus4 = imem_addr + 32'd4;
    end
  end

  assign count = cnt;

endmodule
